// File: rtl/spec_env.sv
// Table-driven environment generator: fires circuit inputs along enabled graph
// transitions and checks circuit output transitions against the same graph.
module spec_env #(
  parameter int NI         = 2,
  parameter int NO         = 2,
  parameter int SB         = 4,
  parameter int NT         = 16,
  parameter int INIT_STATE = 0,
  parameter int INIT_IN    = 0,
  parameter int DL_CYCLES  = 8,
  localparam int SW = (NI + NO > 1) ? $clog2(NI + NO) : 1,
  localparam int FW = $clog2(NI + 1),
  localparam int EW = 1 + SB + SW + 1 + SB,
  localparam int AW = (NT > 1) ? $clog2(NT) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [EW-1:0] cfg_data,
  input  logic          run,
  input  logic [FW-1:0] fire,
  output logic          fire_ok,
  output logic [NI-1:0] env_in,
  input  logic [NO-1:0] circ_out,
  output logic [SB-1:0] state,
  output logic          violation,
  output logic [SW-1:0] viol_sig,
  output logic          viol_dir,
  output logic          deadlock
);

  localparam int CW = $clog2(DL_CYCLES + 1);

  logic [EW-1:0] tbl_q [NT];
  logic [SB-1:0] state_q, state_d;
  logic [NI-1:0] env_q, env_d;
  logic [NO-1:0] out_q, out_d;
  logic          viol_q, viol_d;
  logic [SW-1:0] vsig_q, vsig_d;
  logic          vdir_q, vdir_d;
  logic          dl_q, dl_d;
  logic [CW-1:0] idle_q, idle_d;

  logic [NO-1:0] chg_s;
  logic          chg_any_s, chg_multi_s, active_s, fire_vld_s, fire_cur_s;
  logic [SW-1:0] low_k_s, q_sig_s;
  logic          low_new_s, q_dir_s, hit_s, upd_s;
  logic [SB-1:0] hit_to_s;

  // Entry layout {valid, from, sig, dir, to}
  function automatic logic entry_hit(input logic [EW-1:0] ent, input logic [SB-1:0] st,
                                     input logic [SW-1:0] sig, input logic dir);
    entry_hit = ent[EW-1] && (ent[EW-2 -: SB] == st) &&
                (ent[SB+SW:SB+1] == sig) && (ent[SB] == dir);
  endfunction

  assign chg_s       = circ_out ^ out_q;
  assign chg_any_s   = |chg_s;
  assign chg_multi_s = |(chg_s & (chg_s - NO'(1)));
  assign active_s    = run & ~viol_q;
  assign fire_vld_s  = (fire < FW'(NI));

  // Lowest changed output bit and current level of the input selected by fire
  always_comb begin
    low_k_s    = '0;
    low_new_s  = 1'b0;
    fire_cur_s = 1'b0;
    for (int k = NO - 1; k >= 0; k--) begin
      low_k_s   = chg_s[k] ? SW'(k) : low_k_s;
      low_new_s = chg_s[k] ? circ_out[k] : low_new_s;
    end
    for (int i = 0; i < NI; i++) begin
      fire_cur_s = (fire == FW'(i)) ? env_q[i] : fire_cur_s;
    end
  end

  // Single lookup query: output change takes precedence over fire
  always_comb begin
    if (chg_any_s) begin
      q_sig_s = SW'(NI) + low_k_s;
      q_dir_s = low_new_s;
    end else begin
      q_sig_s = SW'(fire);
      q_dir_s = ~fire_cur_s;
    end
  end

  // Lowest-index matching entry wins, hence the descending scan
  always_comb begin
    hit_s    = 1'b0;
    hit_to_s = '0;
    for (int e = NT - 1; e >= 0; e--) begin
      hit_to_s = entry_hit(tbl_q[e], state_q, q_sig_s, q_dir_s) ? tbl_q[e][SB-1:0] : hit_to_s;
      hit_s    = entry_hit(tbl_q[e], state_q, q_sig_s, q_dir_s) ? 1'b1 : hit_s;
    end
  end

  assign fire_ok = active_s & ~chg_any_s & fire_vld_s & hit_s;

  // Next-state: compliance check, transition, deadlock tracking
  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    out_d   = out_q;
    viol_d  = viol_q;
    vsig_d  = vsig_q;
    vdir_d  = vdir_q;
    upd_s   = 1'b0;
    if (active_s) begin
      out_d = circ_out;
      if (chg_multi_s) begin
        viol_d = 1'b1;
        vsig_d = SW'(NI) + low_k_s;
        vdir_d = low_new_s;
      end else if (chg_any_s && hit_s) begin
        state_d = hit_to_s;
        upd_s   = 1'b1;
      end else if (chg_any_s) begin
        viol_d = 1'b1;
        vsig_d = q_sig_s;
        vdir_d = q_dir_s;
      end else if (fire_ok) begin
        state_d = hit_to_s;
        env_d   = env_q ^ (NI'(1) << fire);
        upd_s   = 1'b1;
      end else begin
        upd_s = 1'b0;
      end
    end else begin
      upd_s = 1'b0;
    end
    if (!run) begin
      idle_d = idle_q;
    end else if (upd_s) begin
      idle_d = '0;
    end else if (idle_q < CW'(DL_CYCLES)) begin
      idle_d = idle_q + CW'(1);
    end else begin
      idle_d = idle_q;
    end
    dl_d = dl_q | (idle_d == CW'(DL_CYCLES));
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SB'(INIT_STATE);
      env_q   <= NI'(INIT_IN);
      out_q   <= '0;
      viol_q  <= 1'b0;
      vsig_q  <= '0;
      vdir_q  <= 1'b0;
      dl_q    <= 1'b0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      env_q   <= env_d;
      out_q   <= out_d;
      viol_q  <= viol_d;
      vsig_q  <= vsig_d;
      vdir_q  <= vdir_d;
      dl_q    <= dl_d;
      idle_q  <= idle_d;
    end
  end

  // Transition table; writes are locked out while running
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int e = 0; e < NT; e++) tbl_q[e] <= '0;
    end else if (cfg_we && !run) begin
      tbl_q[cfg_addr] <= cfg_data;
    end
  end

  assign state     = state_q;
  assign env_in    = env_q;
  assign violation = viol_q;
  assign viol_sig  = vsig_q;
  assign viol_dir  = vdir_q;
  assign deadlock  = dl_q;

endmodule

// File: tb/tb_spec_env.sv
// Scoreboard bench for spec_env on a req/ack handshake graph (NI=1, NO=1).
module tb_spec_env;
  localparam int NI = 1, NO = 1, SB = 4, NT = 16, DL = 8;
  localparam int SW = 1, FW = 1, AW = 4, EW = 1 + SB + SW + 1 + SB;

  logic          clk = 1'b0;
  logic          reset, cfg_we, run;
  logic [AW-1:0] cfg_addr;
  logic [EW-1:0] cfg_data;
  logic [FW-1:0] fire;
  logic          fire_ok;
  logic [NI-1:0] env_in;
  logic [NO-1:0] circ_out;
  logic [SB-1:0] state;
  logic          violation;
  logic [SW-1:0] viol_sig;
  logic          viol_dir, deadlock;

  spec_env #(.NI(NI), .NO(NO), .SB(SB), .NT(NT), .INIT_STATE(0), .INIT_IN(0), .DL_CYCLES(DL)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .run(run), .fire(fire), .fire_ok(fire_ok), .env_in(env_in), .circ_out(circ_out),
    .state(state), .violation(violation), .viol_sig(viol_sig), .viol_dir(viol_dir),
    .deadlock(deadlock)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic       ok;
    logic [3:0] st;
    logic       env, viol, vsig, vdir, dl;
  } exp_t;

  exp_t       sb_q[$];
  int         checks = 0, failures = 0, step_id = 0;
  logic [3:0] e_st;
  logic       e_env, e_viol, e_vsig, e_vdir, e_dl;

  function automatic logic [EW-1:0] ent(input logic [3:0] from, input logic sig,
                                        input logic dir, input logic [3:0] to);
    ent = {1'b1, from, sig, dir, to};
  endfunction

  task automatic cmp(input int id, input string nm, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL step%0d %s actual=%0h required=%0h", id, nm, act, req);
    end
  endtask

  // Monitor: mid-cycle, compare the DUT against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      cmp(e.id, "fire_ok",   {3'b000, fire_ok},   {3'b000, e.ok});
      cmp(e.id, "state",     state,               e.st);
      cmp(e.id, "env_in",    {3'b000, env_in},    {3'b000, e.env});
      cmp(e.id, "violation", {3'b000, violation}, {3'b000, e.viol});
      cmp(e.id, "viol_sig",  {3'b000, viol_sig},  {3'b000, e.vsig});
      cmp(e.id, "viol_dir",  {3'b000, viol_dir},  {3'b000, e.vdir});
      cmp(e.id, "deadlock",  {3'b000, deadlock},  {3'b000, e.dl});
    end
  end

  task automatic drive(input logic rst, input logic r, input logic f, input logic c,
                       input logic we, input logic [3:0] a, input logic [EW-1:0] d,
                       input logic ok);
    exp_t x;
    @(posedge clk);
    #2;
    reset = rst; run = r; fire = f; circ_out = c;
    cfg_we = we; cfg_addr = a; cfg_data = d;
    x.id = step_id; x.ok = ok; x.st = e_st; x.env = e_env;
    x.viol = e_viol; x.vsig = e_vsig; x.vdir = e_vdir; x.dl = e_dl;
    sb_q.push_back(x);
    step_id++;
  endtask

  task automatic go(input logic r, input logic f, input logic c, input logic ok);
    drive(1'b0, r, f, c, 1'b0, 4'd0, 11'd0, ok);
  endtask

  task automatic program_table();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, ent(4'd0, 1'b0, 1'b1, 4'd1), 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd1, ent(4'd1, 1'b1, 1'b1, 4'd2), 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd2, ent(4'd2, 1'b0, 1'b0, 4'd3), 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd3, ent(4'd3, 1'b1, 1'b0, 4'd0), 1'b0);
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; fire = 1'b1; circ_out = 1'b0;
    cfg_we = 1'b0; cfg_addr = 4'd0; cfg_data = 11'd0;
    e_st = 4'd0; e_env = 1'b0; e_viol = 1'b0; e_vsig = 1'b0; e_vdir = 1'b0; e_dl = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    program_table();
    // handshake round trip
    go(1'b1, 1'b0, 1'b0, 1'b1);                 // req+ accepted in state 0
    e_st = 4'd1; e_env = 1'b1;
    go(1'b1, 1'b0, 1'b0, 1'b0);                 // req- not enabled in state 1
    go(1'b1, 1'b1, 1'b1, 1'b0);                 // ack+
    e_st = 4'd2;
    go(1'b1, 1'b0, 1'b1, 1'b1);                 // req-
    e_st = 4'd3; e_env = 1'b0;
    go(1'b1, 1'b1, 1'b0, 1'b0);                 // ack-
    e_st = 4'd0;
    // table write while running must be ignored
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 11'd0, 1'b0);
    go(1'b1, 1'b0, 1'b0, 1'b1);                 // req+ still enabled
    e_st = 4'd1; e_env = 1'b1;
    // eight idle cycles then deadlock
    for (int i = 0; i < DL; i++) go(1'b1, 1'b1, 1'b0, 1'b0);
    e_dl = 1'b1;
    go(1'b1, 1'b1, 1'b1, 1'b0);                 // ack+ resumes activity
    e_st = 4'd2;
    go(1'b1, 1'b1, 1'b0, 1'b0);                 // ack- illegal in state 2
    e_viol = 1'b1; e_vsig = 1'b1; e_vdir = 1'b0;
    go(1'b1, 1'b0, 1'b0, 1'b0);                 // fire ignored after violation
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 11'd0, 1'b0);
    e_st = 4'd0; e_env = 1'b0; e_viol = 1'b0; e_vsig = 1'b0; e_vdir = 1'b0; e_dl = 1'b0;
    go(1'b1, 1'b0, 1'b0, 1'b0);                 // table invalid after reset
    // ack+ in state 0 is a violation; fire ignored with output change present
    program_table();
    go(1'b1, 1'b0, 1'b1, 1'b0);
    e_viol = 1'b1; e_vsig = 1'b1; e_vdir = 1'b1;
    go(1'b1, 1'b0, 1'b1, 1'b0);
    go(1'b1, 1'b1, 1'b1, 1'b0);

    for (int w = 0; w < 20 && sb_q.size() > 0; w++) @(posedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
